// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the fetch PC controller: next-PC selects and FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pc_ctrl_pkg;

  // Next-PC select codes from the branch unit; the remaining codes (3'b100..3'b111)
  // are reserved and fall back to sequential fetch.
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b011;

  // Interrupt sequencing states.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_ENTER   = 2'b01,
    ST_HANDLER = 2'b10
  } state_e;

endpackage

// File: rtl/pc_ctrl_npc_calc.sv
// Purpose: combinational next-fetch-address calculation from the branch-unit select.
// Latency: 0 cycles (pure combinational).
// Backpressure: stall holds the PC only for sequential fetch; any redirect wins over stall.
// Ports: npc_op_i (select), pc_i (current fetch PC), ex_pc_i/ex_imm_i (EX PC and immediate),
//        jalr_base_i (forwarded rs1), stall_i (hazard hold) -> npc_o (candidate next PC).
module npc_calc
  import pc_ctrl_pkg::*;
(
  input  logic [2:0]  npc_op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] jalr_base_i,
  input  logic        stall_i,
  output logic [31:0] npc_o
);

  logic [31:0] jalr_sum;

  // All sums are 32-bit wide so the carry out is dropped (wrap-around).
  assign jalr_sum = jalr_base_i + ex_imm_i;

  always_comb begin
    npc_o = pc_i + 32'd4;
    case (npc_op_i)
      NPC_BRANCH, NPC_JUMP: npc_o = ex_pc_i + ex_imm_i;
      NPC_JALR:             npc_o = jalr_sum & 32'hFFFF_FFFE;
      // PLUS4 and every reserved code: sequential fetch, frozen while stalled.
      default:              npc_o = stall_i ? pc_i : (pc_i + 32'd4);
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Purpose: fetch PC register with branch redirect and single-level interrupt entry/return.
// Latency: 1 cycle for PC updates; 2 cycles from interrupt acceptance to handler fetch.
// Backpressure: stall freezes sequential fetch; interrupts are deferred (not dropped)
//               while a redirect, stall or mret is present, and masked inside the handler.
// Ports: clk, rstn (sync active-low); NPCOp, ex_pc, ex_imm, jalr_base, stall, int_req, mret in;
//        pc_out, interrupt_tick, int_flush, epc out (all registered).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] jalr_base,
  input  logic        stall,
  input  logic        int_req,
  input  logic        mret,
  output logic [31:0] pc_out,
  output logic        interrupt_tick,
  output logic        int_flush,
  output logic [31:0] epc
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        tick_q, tick_d;
  logic [31:0] npc;
  logic        accept;

  npc_calc u_npc_calc (
    .npc_op_i    (NPCOp),
    .pc_i        (pc_q),
    .ex_pc_i     (ex_pc),
    .ex_imm_i    (ex_imm),
    .jalr_base_i (jalr_base),
    .stall_i     (stall),
    .npc_o       (npc)
  );

  // Only take the interrupt on a quiet sequential-fetch cycle so the saved
  // return address is unambiguous; otherwise it is simply retried next cycle.
  assign accept = (state_q == ST_RUN) && int_req && (NPCOp == NPC_PLUS4)
                  && !stall && !mret;

  always_comb begin
    state_d = state_q;
    pc_d    = npc;
    epc_d   = epc_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          epc_d   = pc_q;
          pc_d    = pc_q;
          state_d = ST_ENTER;
          tick_d  = 1'b1;   // registered so it is high exactly while in ENTER
        end
      end
      ST_ENTER: begin
        pc_d    = HANDLER_VEC;
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (mret) begin
          pc_d    = epc_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        // Unused encoding: hold the PC and recover to RUN.
        pc_d    = pc_q;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tick_q  <= tick_d;
    end
  end

  assign pc_out         = pc_q;
  assign epc            = epc_q;
  assign interrupt_tick = tick_q;
  assign int_flush      = tick_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Purpose: self-checking bench for pc_ctrl: vector table, directed interrupt sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  NPCOp;
  logic [31:0] ex_pc, ex_imm, jalr_base;
  logic        stall, int_req, mret;
  logic [31:0] pc_out, epc;
  logic        interrupt_tick, int_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.RESET_PC(32'h0000_0000), .HANDLER_VEC(32'h0000_0100)) dut (
    .clk(clk), .rstn(rstn), .NPCOp(NPCOp), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .jalr_base(jalr_base), .stall(stall), .int_req(int_req), .mret(mret),
    .pc_out(pc_out), .interrupt_tick(interrupt_tick), .int_flush(int_flush), .epc(epc)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] xpc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        stl;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic e_tick);
    chk({nm, "_pc"}, pc_out, e_pc);
    chk({nm, "_epc"}, epc, e_epc);
    chk({nm, "_tick"}, {31'b0, interrupt_tick}, {31'b0, e_tick});
    chk({nm, "_flush"}, {31'b0, int_flush}, {31'b0, e_tick});
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    NPCOp = NPC_PLUS4; ex_pc = '0; ex_imm = '0; jalr_base = '0;
    stall = 1'b0; int_req = 1'b0; mret = 1'b0; rstn = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  // Reference model: phases 0=running, 1=entering handler, 2=in handler.
  logic [31:0] m_pc, m_epc;
  int          m_phase;

  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    logic [31:0] t;
    if (NPCOp == 3'd1 || NPCOp == 3'd2) return ex_pc + ex_imm;
    if (NPCOp == 3'd3) begin
      t = jalr_base + ex_imm;
      return {t[31:1], 1'b0};
    end
    return stall ? pc : pc + 32'd4;
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      m_pc = 32'h0; m_epc = 32'h0; m_phase = 0;
    end else if (m_phase == 1) begin
      m_pc = 32'h100; m_phase = 2;
    end else if (m_phase == 2) begin
      if (mret) begin m_pc = m_epc; m_phase = 0; end
      else m_pc = seq_next(m_pc);
    end else begin
      if (int_req && NPCOp == 3'd0 && !stall && !mret) begin
        m_epc = m_pc; m_phase = 1;
      end else m_pc = seq_next(m_pc);
    end
  endtask

  initial begin
    vt[0]  = '{NPC_PLUS4,  32'h0,         32'h0,         32'h0,         1'b0, 32'h0000_0004};
    vt[1]  = '{NPC_PLUS4,  32'h0,         32'h0,         32'h0,         1'b1, 32'h0000_0004};
    vt[2]  = '{NPC_BRANCH, 32'h20,        32'hFFFF_FFF0, 32'h0,         1'b1, 32'h0000_0010};
    vt[3]  = '{NPC_JALR,   32'h0,         32'h4,         32'h103,       1'b0, 32'h0000_0106};
    vt[4]  = '{NPC_JUMP,   32'h1000,      32'h234,       32'h0,         1'b0, 32'h0000_1234};
    vt[5]  = '{3'b101,     32'h5000,      32'h40,        32'h0,         1'b0, 32'h0000_1238};
    vt[6]  = '{3'b111,     32'h5000,      32'h40,        32'h0,         1'b1, 32'h0000_1238};
    vt[7]  = '{NPC_JUMP,   32'hFFFF_FFF0, 32'hC,         32'h0,         1'b1, 32'hFFFF_FFFC};
    vt[8]  = '{NPC_PLUS4,  32'h0,         32'h0,         32'h0,         1'b0, 32'h0000_0000};
    vt[9]  = '{NPC_JALR,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE};
    vt[10] = '{NPC_BRANCH, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 32'h0000_0000};
    vt[11] = '{NPC_JALR,   32'h0,         32'hFFFF_FFF5, 32'h10,        1'b1, 32'h0000_0004};

    // Reset values and sequential fetch.
    do_reset();
    chk_all("reset", 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("plus4_%0d", i), pc_out, 32'(i * 4));
    end

    // Vector table: each row applied for one edge from the previous row's PC.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      NPCOp = vt[i].op; ex_pc = vt[i].xpc; ex_imm = vt[i].imm;
      jalr_base = vt[i].base; stall = vt[i].stl;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].exp_pc, 32'h0, 1'b0);
    end

    // Interrupt entry, masking inside the handler, and mret return.
    do_reset();
    NPCOp = NPC_JUMP; ex_pc = 32'h40; ex_imm = 32'h0;
    step();
    chk("goto40", pc_out, 32'h40);
    quiet(); int_req = 1'b1;
    step();
    chk_all("accept", 32'h40, 32'h40, 1'b1);
    NPCOp = NPC_JUMP; ex_pc = 32'h800;   // must be ignored during entry
    step();
    chk_all("enter", 32'h100, 32'h40, 1'b0);
    NPCOp = NPC_PLUS4;                    // int_req still high: masked
    step();
    chk_all("handler_mask", 32'h104, 32'h40, 1'b0);
    mret = 1'b1; NPCOp = NPC_JUMP; stall = 1'b1;
    step();
    chk_all("mret", 32'h40, 32'h40, 1'b0);
    quiet(); mret = 1'b1; int_req = 1'b1;  // mret in RUN blocks acceptance
    step();
    chk_all("run_mret", 32'h44, 32'h40, 1'b0);
    mret = 1'b0; stall = 1'b1;              // stall defers the interrupt
    step();
    chk_all("stall_defer", 32'h44, 32'h40, 1'b0);

    // Interrupt coincident with a jump: jump first, entry one cycle later.
    do_reset();
    int_req = 1'b1; NPCOp = NPC_JUMP; ex_pc = 32'h200; ex_imm = 32'h10;
    step();
    chk_all("jump_defer", 32'h210, 32'h0, 1'b0);
    NPCOp = NPC_PLUS4;
    step();
    chk_all("late_accept", 32'h210, 32'h210, 1'b1);
    step();
    chk_all("late_enter", 32'h100, 32'h210, 1'b0);

    // Reset inside the handler, then no interrupt is left pending.
    quiet();
    rstn = 1'b0;
    step();
    chk_all("rst_handler", 32'h0, 32'h0, 1'b0);
    rstn = 1'b1;
    step();
    chk_all("post_rst", 32'h4, 32'h0, 1'b0);

    // Reset while in ENTER.
    int_req = 1'b1;
    step();
    chk("pre_enter_tick", {31'b0, interrupt_tick}, 32'h1);
    int_req = 1'b0; rstn = 1'b0;
    step();
    chk_all("rst_enter", 32'h0, 32'h0, 1'b0);
    rstn = 1'b1;

    // Randomised run against the reference model.
    do_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_phase = 0;
    for (int n = 0; n < 3000; n++) begin
      NPCOp     = ($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(0, 7));
      ex_pc     = $urandom();
      ex_imm    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32;
      jalr_base = $urandom();
      stall     = ($urandom_range(0, 3) == 0);
      int_req   = ($urandom_range(0, 4) == 0);
      mret      = ($urandom_range(0, 9) == 0);
      rstn      = ($urandom_range(0, 99) != 0);
      model_edge();
      step();
      chk_all($sformatf("rnd%0d", n), m_pc, m_epc, (m_phase == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
